// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative 32-bit signed multiply / divide.
// Shift-add multiply and non-restoring divide run on operand magnitudes,
// one iteration per cycle for 32 cycles. The sign is applied at the end.
module multdiv_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

   state_t      state_q, state_d;
   logic        mult_q, mult_d, div_q, div_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        isdiv_q, isdiv_d, neg_q, neg_d, bzero_q, bzero_d;
   // hi: multiply upper accumulator / divide partial remainder (signed, with headroom)
   // lo: multiply multiplier->product low half / divide dividend->quotient
   logic [33:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d, opb_q, opb_d;
   logic [31:0] res_q, res_d;
   logic        exc_q, exc_d, rdy_q, rdy_d;

   logic        mult_start, div_start, start;
   logic [31:0] a_mag, b_mag, quo;
   logic [33:0] mul_sum, div_sh, div_r;
   logic [63:0] prod_mag, prod;

   // Datapath terms shared by the next-state logic
   always_comb begin
      mult_start = ctrl_MULT & ~mult_q;
      div_start  = ctrl_DIV & ~div_q;
      // Both edges together cancel: no new operation is launched
      start      = mult_start ^ div_start;
      // 0x80000000 negates to itself, which is the correct unsigned magnitude
      a_mag      = data_operandA[31] ? -data_operandA : data_operandA;
      b_mag      = data_operandB[31] ? -data_operandB : data_operandB;
      mul_sum    = {2'b00, hi_q[31:0]} + (lo_q[0] ? {2'b00, opb_q} : 34'd0);
      div_sh     = {hi_q[32:0], lo_q[31]};
      div_r      = hi_q[33] ? div_sh + {2'b00, opb_q} : div_sh - {2'b00, opb_q};
      prod_mag   = {hi_q[31:0], lo_q};
      prod       = neg_q ? -prod_mag : prod_mag;
      quo        = neg_q ? -lo_q : lo_q;
   end

   // FSM next state, iteration step and output evaluation
   always_comb begin
      state_d = state_q;
      mult_d  = ctrl_MULT;
      div_d   = ctrl_DIV;
      cnt_d   = cnt_q;
      isdiv_d = isdiv_q;
      neg_d   = neg_q;
      bzero_d = bzero_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opb_d   = opb_q;
      res_d   = res_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;
      if (start) begin
         // Accepted in any state; an operation in flight is abandoned
         state_d = RUN;
         cnt_d   = 5'd0;
         isdiv_d = div_start;
         neg_d   = data_operandA[31] ^ data_operandB[31];
         bzero_d = (data_operandB == 32'd0);
         hi_d    = 34'd0;
         lo_d    = div_start ? a_mag : b_mag;
         opb_d   = div_start ? b_mag : a_mag;
      end else begin
         case (state_q)
            RUN: begin
               if (isdiv_q) begin
                  hi_d = div_r;
                  lo_d = {lo_q[30:0], ~div_r[33]};
               end else begin
                  hi_d = {1'b0, mul_sum[33:1]};
                  lo_d = {mul_sum[0], lo_q[31:1]};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_d = FIN;
            end
            FIN: begin
               state_d = DONE;
               rdy_d   = 1'b1;
               if (!isdiv_q) begin
                  res_d = prod[31:0];
                  exc_d = (prod[63:32] != {32{prod[31]}});
               end else if (bzero_q) begin
                  res_d = 32'd0;
                  exc_d = 1'b1;
               end else begin
                  // Only -2^31 / -1 gives a positive quotient of 2^31
                  res_d = quo;
                  exc_d = ~neg_q & lo_q[31];
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         mult_q  <= 1'b0;
         div_q   <= 1'b0;
         cnt_q   <= 5'd0;
         isdiv_q <= 1'b0;
         neg_q   <= 1'b0;
         bzero_q <= 1'b0;
         hi_q    <= 34'd0;
         lo_q    <= 32'd0;
         opb_q   <= 32'd0;
         res_q   <= 32'd0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mult_q  <= mult_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         isdiv_q <= isdiv_d;
         neg_q   <= neg_d;
         bzero_q <= bzero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Testbench for multdiv_seq: directed table, randomized ops against a
// plain-arithmetic model, and hand-written level/abort/reset sequences.
module tb_multdiv_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = 32'd0;
   logic [31:0] data_operandB = 32'd0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int total = 0;
   int bad   = 0;

   multdiv_seq dut (
      .clock(clock), .reset(reset),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        isdiv;
      logic [31:0] a, b, r;
      logic        e;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference: signed arithmetic straight from the operation rules
   function automatic void model(input logic isdiv, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint p;
      if (!isdiv) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0; e = 1'b1;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         r = 32'h80000000; e = 1'b1;
      end else begin
         r = 32'($signed(a) / $signed(b)); e = 1'b0;
      end
   endfunction

   // Called at a negedge: request is high across exactly one rising edge (E0)
   task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      data_operandA = a; data_operandB = b;
      ctrl_MULT = m; ctrl_DIV = d;
      @(negedge clock);
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
   endtask

   // Samples the k-th negedge after the start edge, k = 1..n
   task automatic watch(input int n, output int cnt, output int first,
                        output logic [31:0] r, output logic e);
      cnt = 0; first = -1; r = 32'd0; e = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         if (data_resultRDY) begin
            cnt++;
            if (first < 0) begin
               first = k; r = data_result; e = data_exception;
            end
         end
      end
   endtask

   task automatic run_op(input string tag, input logic isdiv, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ee);
      int cnt, first;
      logic [31:0] r;
      logic e;
      pulse(~isdiv, isdiv, a, b);
      watch(36, cnt, first, r, e);
      chk({tag, "_rdy_at"}, first, 33);
      chk({tag, "_rdy_cnt"}, cnt, 1);
      chk({tag, "_res"}, r, er);
      chk({tag, "_exc"}, {31'd0, e}, {31'd0, ee});
   endtask

   function automatic logic [31:0] rnd_val();
      logic [31:0] sp [6];
      sp[0] = 32'h80000000; sp[1] = 32'hFFFFFFFF; sp[2] = 32'h7FFFFFFF;
      sp[3] = 32'd0; sp[4] = 32'd1; sp[5] = 32'h00010000;
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($signed($urandom_range(0, 200)) - 100);
         2:       return sp[$urandom_range(0, 5)];
         default: return 32'($signed($urandom) >>> 16);
      endcase
   endfunction

   initial begin
      int cnt, first;
      logic [31:0] r, er;
      logic e, ee, op;

      tbl[0]  = '{1'b0, 32'd7,        32'd6,        32'd42,       1'b0};
      tbl[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
      tbl[2]  = '{1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd15,       1'b0};
      tbl[3]  = '{1'b0, 32'h00010000, 32'h00010000, 32'd0,        1'b1};
      tbl[4]  = '{1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
      tbl[5]  = '{1'b1, 32'd5,        32'd0,        32'd0,        1'b1};
      tbl[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
      tbl[7]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
      tbl[8]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
      tbl[9]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
      tbl[10] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
      tbl[11] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        1'b1};
      tbl[12] = '{1'b1, 32'h80000000, 32'h80000000, 32'd1,        1'b0};
      tbl[13] = '{1'b1, 32'd0,        32'hFFFFFFFB, 32'd0,        1'b0};

      // Reset state
      #2 reset = 1'b0;
      #1;
      chk("rst_res", data_result, 32'd0);
      chk("rst_exc", {31'd0, data_exception}, 32'd0);
      chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Directed table
      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), tbl[i].isdiv, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].e);

      // Randomized ops against the model
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         op = 1'($urandom_range(0, 1));
         a = rnd_val();
         b = rnd_val();
         model(op, a, b, er, ee);
         run_op($sformatf("rnd%0d_%s_%h_%h", i, op ? "div" : "mul", a, b), op, a, b, er, ee);
      end

      // Held-high request triggers once
      data_operandA = 32'd3; data_operandB = 32'd4; ctrl_MULT = 1'b1;
      @(negedge clock);
      watch(60, cnt, first, r, e);
      ctrl_MULT = 1'b0;
      chk("hold_rdy_cnt", cnt, 1);
      chk("hold_rdy_at", first, 33);
      chk("hold_res", r, 32'd12);

      // Abort DIV with a MULT started 10 cycles in
      pulse(1'b0, 1'b1, 32'd100, 32'd10);
      watch(9, cnt, first, r, e);
      chk("abort_early_rdy", cnt, 0);
      pulse(1'b1, 1'b0, 32'd2, 32'd9);
      watch(40, cnt, first, r, e);
      chk("abort_rdy_cnt", cnt, 1);
      chk("abort_rdy_at", first, 33);
      chk("abort_res", r, 32'd18);

      // Simultaneous MULT and DIV: nothing starts, outputs hold
      pulse(1'b1, 1'b1, 32'd6, 32'd6);
      watch(40, cnt, first, r, e);
      chk("both_rdy_cnt", cnt, 0);
      chk("both_res_hold", data_result, 32'd18);

      // Reset in the middle of a DIV
      pulse(1'b0, 1'b1, 32'd1000, 32'd3);
      watch(19, cnt, first, r, e);
      #2 reset = 1'b0;
      #1;
      chk("midrst_res", data_result, 32'd0);
      chk("midrst_exc", {31'd0, data_exception}, 32'd0);
      chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      watch(40, cnt, first, r, e);
      chk("midrst_no_rdy", cnt, 0);
      chk("midrst_res_after", data_result, 32'd0);

      // A normal op still works after the disturbance
      run_op("post", 1'b1, 32'd1000, 32'd3, 32'd333, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Iterative 32-bit signed multiply/divide unit that sits beside the execute stage of the 5-stage pipeline. The execute stage presents operands and a mult or div request; this unit produces the result, an exception flag and a one-cycle ready strobe. The product register downstream captures the result, and the stall controller holds the pipeline until that strobe. The datapath is shift-add multiply and non-restoring divide: 32 iterations each, no combinational 32x32 array.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clock` in 1: master clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; `reset`=0 clears all state immediately
- `data_operandA` in 32: multiplicand / dividend, two's complement
- `data_operandB` in 32: multiplier / divisor, two's complement
- `ctrl_MULT` in 1: multiply request (level; a start is its rising edge)
- `ctrl_DIV` in 1: divide request (level; a start is its rising edge)
- `data_result` out 32: low 32 bits of product, or quotient
- `data_exception` out 1: overflow (mult) or divide-by-zero/overflow (div)
- `data_resultRDY` out 1: one-cycle strobe, result valid

## Operation
- Start detect:
  - Registered copies `mult_q`/`div_q` of the request inputs.
  - MULT start = `ctrl_MULT & ~mult_q`; DIV start = `ctrl_DIV & ~div_q`.
  - A held-high request never retriggers.
  - MULT start and DIV start in the same cycle: no operation; the state is unchanged.
- FSM states and transitions:
  - IDLE → RUN on start. Latch |A|, |B|, result sign, op, and zero-divisor flag. Iteration counter = 0.
  - RUN → RUN while counter < 31, one iteration per cycle, counter++.
  - RUN → FIN when counter = 31.
  - FIN → DONE: apply sign, compute exception, register outputs, assert `data_resultRDY`.
  - DONE → IDLE on the next cycle. `data_resultRDY` drops.
- Restart: a valid start in RUN or FIN aborts the current operation and re-enters RUN with the new operands. No RDY is produced for the aborted operation.
- Multiply:
  - 64-bit unsigned shift-add on the magnitudes; negate if the signs differ.
  - `data_result` = product[31:0].
  - `data_exception` = 1 iff the signed 64-bit product ≠ sign-extension of product[31:0].
- Divide:
  - Non-restoring on the magnitudes, truncation toward zero.
  - Quotient sign = signA ^ signB. The remainder is discarded.
  - B = 0 → `data_result` = 0, `data_exception` = 1. The full latency is still taken.
  - A = 0x80000000 and B = 0xFFFFFFFF → `data_result` = 0x80000000, `data_exception` = 1.
- Magnitude of 0x80000000: handled as unsigned 0x80000000. The internal registers are 33 bits where needed.
- `data_result` and `data_exception` hold their values from DONE until the next FIN. They are not cleared on start.

## Timing
- Reset (`reset`=0, asynchronous):
  - State = IDLE.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
  - `mult_q` = `div_q` = 0, counter = 0.
- Reset mid-operation discards the operation. No RDY follows the release of reset.
- Latency:
  - Start sampled at edge E0.
  - Iterations occur at edges E1..E32.
  - FIN evaluates at E33.
  - `data_resultRDY` = 1 for exactly the cycle between E33 and E34. Start to RDY = 33 cycles, for both mult and div.
- Throughput: a new start is accepted at E34 (in IDLE). A start in the DONE cycle is also accepted (DONE → RUN), so back-to-back issue gives one op per 34 cycles.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Operand inputs are don't-care after E0.

## Test plan
- Positive mult:
  - Stimulus: A=7, B=6, pulse `ctrl_MULT` 1 cycle.
  - Required: `data_resultRDY` high exactly 33 cycles later, `data_result`=42, `data_exception`=0. RDY low at every other cycle.
- Signed div and mult:
  - A=-100, B=7, DIV → result -14 (0xFFFFFFF2), exc 0.
  - Then A=-3, B=-5, MULT → 15, exc 0.
- Mult overflow:
  - A=0x00010000, B=0x00010000 → result 0x00000000, exc 1.
  - A=0x80000000, B=1 → 0x80000000, exc 0.
- Divide exceptions:
  - A=5, B=0 → result 0, exc 1, RDY at cycle 33.
  - A=0x80000000, B=-1 → 0x80000000, exc 1.
- Level hold and abort:
  - Hold `ctrl_MULT` high for 60 cycles with A=3, B=4 → exactly one RDY (result 12).
  - Start DIV 100/10, then at cycle 10 start MULT 2×9 → single RDY 33 cycles after the MULT start, result 18.
- Reset behaviour:
  - Assert `reset`=0 at cycle 20 of a DIV → outputs 0 immediately, no RDY for 40 cycles after release.
  - Assert MULT and DIV simultaneously → no RDY.
